// File: rtl/pipe_ctrl_if.sv
// Stage-side request/redirect bundle and the controller's per-stage hold, flush and PC redirect outputs.
interface pipe_ctrl_if #(
  parameter int ADDR_W = 32
);
  logic              if_stall_req;
  logic              id_stall_req;
  logic              ex_stall_req;
  logic              mem_stall_req;
  logic              ex_redirect;
  logic [ADDR_W-1:0] ex_target;
  logic [5:0]        stall;
  logic              flush;
  logic              pc_load;
  logic [ADDR_W-1:0] pc_target;
  logic              fetch_kill;

  modport master (
    input  if_stall_req, id_stall_req, ex_stall_req, mem_stall_req, ex_redirect, ex_target,
    output stall, flush, pc_load, pc_target, fetch_kill
  );

  modport slave (
    output if_stall_req, id_stall_req, ex_stall_req, mem_stall_req, ex_redirect, ex_target,
    input  stall, flush, pc_load, pc_target, fetch_kill
  );
endinterface

// File: rtl/pipe_ctrl.sv
// Pipeline stall/flush controller: stall, flush and PC redirect are combinational (zero latency);
// rdy=0 freezes every register and forces all stages to hold. fetch_kill is decoded from state.
module pipe_ctrl #(
  parameter int FLUSH_CYCLES = 2,
  parameter int ADDR_W       = 32,
  parameter int CNT_W        = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  input  logic              perf_clr,
  pipe_ctrl_if.master       pif,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  typedef enum logic [1:0] {RUN, PEND, FLUSH} state_t;

  localparam logic [3:0] KILL_INIT = 4'(FLUSH_CYCLES);
  localparam logic [5:0] S_MEM     = 6'b011111;
  localparam logic [5:0] S_EX      = 6'b001111;
  localparam logic [5:0] S_ID      = 6'b000111;
  localparam logic [5:0] S_IF      = 6'b000011;

  state_t            state, state_nxt;
  logic [3:0]        kill_cnt, kill_nxt;
  logic [ADDR_W-1:0] tgt_q, tgt_nxt, tgt_out;
  logic [5:0]        enc_late, enc_full, stall_c;
  logic              load_c, eff_redir;

  // enc_late covers only the requests that stay valid while wrong-path work drains
  always_comb begin
    enc_late = 6'b0;
    if (pif.mem_stall_req)     enc_late = S_MEM;
    else if (pif.ex_stall_req) enc_late = S_EX;
    enc_full = enc_late;
    if (enc_late == 6'b0) begin
      if (pif.id_stall_req)      enc_full = S_ID;
      else if (pif.if_stall_req) enc_full = S_IF;
    end
  end

  always_comb begin
    state_nxt = state;
    kill_nxt  = kill_cnt;
    tgt_nxt   = tgt_q;
    stall_c   = enc_full;
    load_c    = 1'b0;
    tgt_out   = '0;
    eff_redir = pif.ex_redirect & ~pif.ex_stall_req;
    case (state)
      RUN: begin
        if (eff_redir) begin
          if (pif.mem_stall_req) begin
            tgt_nxt   = pif.ex_target;
            state_nxt = PEND;
          end else begin
            stall_c   = 6'b0;
            load_c    = 1'b1;
            tgt_out   = pif.ex_target;
            kill_nxt  = KILL_INIT;
            state_nxt = FLUSH;
          end
        end
      end
      PEND: begin
        if (pif.mem_stall_req) begin
          stall_c = S_MEM;
        end else begin
          stall_c   = 6'b0;
          load_c    = 1'b1;
          tgt_out   = tgt_q;
          kill_nxt  = KILL_INIT;
          state_nxt = FLUSH;
        end
      end
      FLUSH: begin
        stall_c  = enc_late;
        kill_nxt = kill_cnt - 4'd1;
        if (kill_cnt <= 4'd1) state_nxt = RUN;
      end
      default: state_nxt = RUN;
    endcase
    if (!rdy) begin
      stall_c   = S_MEM;
      load_c    = 1'b0;
      tgt_out   = '0;
      state_nxt = state;
      kill_nxt  = kill_cnt;
      tgt_nxt   = tgt_q;
    end
    if (rst) begin
      stall_c = 6'b0;
      load_c  = 1'b0;
      tgt_out = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= RUN;
      kill_cnt <= 4'd0;
      tgt_q    <= '0;
    end else begin
      state    <= state_nxt;
      kill_cnt <= kill_nxt;
      tgt_q    <= tgt_nxt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else if (rdy) begin
      if (perf_clr) begin
        stall_cnt <= '0;
        flush_cnt <= '0;
      end else begin
        if (stall_c != 6'b0 && stall_cnt != '1) stall_cnt <= stall_cnt + 1'b1;
        if (load_c && flush_cnt != '1)          flush_cnt <= flush_cnt + 1'b1;
      end
    end
  end

  assign pif.stall      = stall_c;
  assign pif.flush      = load_c;
  assign pif.pc_load    = load_c;
  assign pif.pc_target  = tgt_out;
  assign pif.fetch_kill = (state == FLUSH);

endmodule

// File: tb/tb_pipe_ctrl.sv
// Scoreboarded bench for pipe_ctrl with FLUSH_CYCLES=2: each step drives one cycle of requests
// and queues the hand-derived outputs expected for that cycle.
module tb_pipe_ctrl;

  localparam logic [7:0] RST = 8'h80, RDY = 8'h40, CLR = 8'h20, IFR = 8'h10;
  localparam logic [7:0] IDR = 8'h08, EXR = 8'h04, MEM = 8'h02, RDR = 8'h01;

  typedef struct packed {
    logic [5:0]  stall;
    logic        ld;
    logic [31:0] pct;
    logic        fk;
  } exp_t;

  logic        clk, rst, rdy, perf_clr;
  logic [31:0] stall_cnt, flush_cnt;
  int          n_chk = 0, n_fail = 0;
  exp_t        sb[$];
  string       tq[$];

  pipe_ctrl_if #(.ADDR_W(32)) pif ();

  pipe_ctrl #(.FLUSH_CYCLES(2), .ADDR_W(32), .CNT_W(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .rdy       (rdy),
    .perf_clr  (perf_clr),
    .pif       (pif),
    .stall_cnt (stall_cnt),
    .flush_cnt (flush_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Entered at posedge+1; samples mid-cycle and returns at the next posedge+1.
  task automatic drive(input logic [7:0] f, input logic [31:0] tgt, input logic [5:0] e_stall,
                       input logic e_ld, input logic [31:0] e_pct, input logic e_fk,
                       input string tag);
    exp_t  e;
    string t;
    rst               = f[7];
    rdy               = f[6];
    perf_clr          = f[5];
    pif.if_stall_req  = f[4];
    pif.id_stall_req  = f[3];
    pif.ex_stall_req  = f[2];
    pif.mem_stall_req = f[1];
    pif.ex_redirect   = f[0];
    pif.ex_target     = tgt;
    e.stall = e_stall;
    e.ld    = e_ld;
    e.pct   = e_pct;
    e.fk    = e_fk;
    sb.push_back(e);
    tq.push_back(tag);
    #3;
    e = sb.pop_front();
    t = tq.pop_front();
    check({t, ".stall"},      64'(pif.stall),      64'(e.stall));
    check({t, ".flush"},      64'(pif.flush),      64'(e.ld));
    check({t, ".pc_load"},    64'(pif.pc_load),    64'(e.ld));
    check({t, ".pc_target"},  64'(pif.pc_target),  64'(e.pct));
    check({t, ".fetch_kill"}, 64'(pif.fetch_kill), 64'(e.fk));
    @(posedge clk);
    #1;
  endtask

  initial begin
    // reset state
    drive(RST | RDY | IDR | MEM, 0, 6'b000000, 0, 0, 0, "reset");
    check("reset.stall_cnt", 64'(stall_cnt), 0);
    check("reset.flush_cnt", 64'(flush_cnt), 0);

    // stall priority encoding
    drive(RDY | IDR, 0, 6'b000111, 0, 0, 0, "id_only");
    check("id_only.stall_cnt", 64'(stall_cnt), 1);
    drive(RDY | MEM | IFR, 0, 6'b011111, 0, 0, 0, "mem_if");
    drive(RDY | IFR,       0, 6'b000011, 0, 0, 0, "if_only");
    drive(RDY | EXR | IDR, 0, 6'b001111, 0, 0, 0, "ex_id");
    check("enc.stall_cnt", 64'(stall_cnt), 4);

    // immediate redirect, then masked requests and ignored redirect during FLUSH
    drive(RDY | RDR | IDR, 32'h1000, 6'b000000, 1, 32'h1000, 0, "redir");
    drive(RDY | IDR,       0,        6'b000000, 0, 0, 1, "flush1_mask");
    drive(RDY | RDR,       32'h5000, 6'b000000, 0, 0, 1, "flush2_ign");
    drive(RDY,             0,        6'b000000, 0, 0, 0, "flush_done");
    check("redir.flush_cnt", 64'(flush_cnt), 1);
    check("redir.stall_cnt", 64'(stall_cnt), 4);

    // redirect held across a 3-cycle mem stall
    drive(RDY | RDR | MEM, 32'h2000, 6'b011111, 0, 0, 0, "pend1");
    drive(RDY | MEM,       0,        6'b011111, 0, 0, 0, "pend2");
    drive(RDY | MEM | RDR, 32'h9000, 6'b011111, 0, 0, 0, "pend3");
    drive(RDY,             0,        6'b000000, 1, 32'h2000, 0, "pend_apply");
    drive(RDY | EXR,       0,        6'b001111, 0, 0, 1, "pend_fk1");
    drive(RDY,             0,        6'b000000, 0, 0, 1, "pend_fk2");
    drive(RDY,             0,        6'b000000, 0, 0, 0, "pend_done");
    check("pend.flush_cnt", 64'(flush_cnt), 2);
    check("pend.stall_cnt", 64'(stall_cnt), 8);

    // redirect suppressed by ex stall, applied once it drops
    drive(RDY | RDR | EXR, 32'h3000, 6'b001111, 0, 0, 0, "exblk");
    drive(RDY | RDR,       32'h3000, 6'b000000, 1, 32'h3000, 0, "exrel");

    // rdy=0 mid-FLUSH freezes the kill window and counters
    drive(8'h00,       0, 6'b011111, 0, 0, 1, "frz1");
    drive(8'h00 | RDR, 0, 6'b011111, 0, 0, 1, "frz2");
    check("frz.stall_cnt", 64'(stall_cnt), 9);
    check("frz.flush_cnt", 64'(flush_cnt), 3);
    drive(RDY, 0, 6'b000000, 0, 0, 1, "thaw1");
    drive(RDY, 0, 6'b000000, 0, 0, 1, "thaw2");
    drive(RDY, 0, 6'b000000, 0, 0, 0, "thaw3");

    // rdy=0 blocks a redirect in RUN
    drive(RDR, 32'h4000, 6'b011111, 0, 0, 0, "rdy0_redir");
    drive(RDY, 0,        6'b000000, 0, 0, 0, "rdy0_after");
    check("rdy0.flush_cnt", 64'(flush_cnt), 3);

    // reset mid-FLUSH
    drive(RDY | RDR, 32'h6000, 6'b000000, 1, 32'h6000, 0, "rf_redir");
    drive(RST | RDY | MEM, 0, 6'b000000, 0, 0, 0, "rst_flush");
    check("rst_flush.flush_cnt", 64'(flush_cnt), 0);
    drive(RDY, 0, 6'b000000, 0, 0, 0, "rst_flush_after");

    // reset mid-PEND discards the stored target
    drive(RDY | RDR | MEM, 32'h7000, 6'b011111, 0, 0, 0, "rp_pend");
    drive(RST | RDY | MEM, 0, 6'b000000, 0, 0, 0, "rst_pend");
    drive(RDY, 0, 6'b000000, 0, 0, 0, "rst_pend_after");

    // perf_clr wins over a same-cycle increment
    drive(RDY | IDR, 0, 6'b000111, 0, 0, 0, "pc_inc");
    check("pc_inc.stall_cnt", 64'(stall_cnt), 1);
    drive(RDY | IDR | CLR, 0, 6'b000111, 0, 0, 0, "pc_clr");
    check("pc_clr.stall_cnt", 64'(stall_cnt), 0);

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule
